// File: rtl/yarvi_tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// yarvi_tx_arbiter_pkg
//   Shared definitions for the tx stream arbiter and the rotate-priority
//   picker: the ASCII line-feed byte that closes a burst, the arbiter state
//   encodings, and a helper that sizes requester-id fields.
// ---------------------------------------------------------------------------
package yarvi_tx_arbiter_pkg;

  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  // Width of a requester id; at least one bit so a 1-requester build still
  // has a legal vector.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/yarvi_rr_pick.sv
// ---------------------------------------------------------------------------
// yarvi_rr_pick
//   Combinational rotate-priority picker. Scans the request vector starting
//   one position after the last winner and wrapping modulo N, returning the
//   first requester found.
// Ports
//   req    in   N   request vector
//   last   in   W   id of the previous winner (lowest priority this round)
//   any    out  1   at least one request is set
//   grant  out  W   id of the chosen requester (0 when any=0)
// ---------------------------------------------------------------------------
module yarvi_rr_pick
  import yarvi_tx_arbiter_pkg::*;
#(
  parameter int  N = 2,
  localparam int W = id_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         any,
  output logic [W-1:0] grant
);

  int         idx;
  logic [W-1:0] idx_w;

  // Offsets 1..N visit every requester exactly once, with the last winner
  // visited at the very end so it only wins again if nobody else asks.
  always_comb begin
    any   = 1'b0;
    grant = '0;
    idx   = 0;
    idx_w = '0;
    for (int off = 1; off <= N; off++) begin
      idx   = (int'(last) + off) % N;
      idx_w = W'(idx);
      if (!any && req[idx_w]) begin
        any   = 1'b1;
        grant = idx_w;
      end
    end
  end

endmodule

// File: rtl/yarvi_tx_arbiter.sv
// ---------------------------------------------------------------------------
// yarvi_tx_arbiter
//   Round-robin arbiter that shares the SoC's single byte-wide tx stream
//   between N requesters. A grant is held for a whole burst, which ends on a
//   line feed, after MAX_BURST bytes, or after IDLE_TIMEOUT cycles in which
//   the granted requester has nothing to send, so console lines from
//   different sources never interleave. The tx side is one output register.
// Ports
//   clock        in   1     clock, all logic on posedge
//   reset        in   1     synchronous, active-high
//   req_valid    in   N     requester i has a byte
//   req_data     in   8*N   byte of requester i in bits [8*i+7:8*i]
//   req_ready    out  N     byte of requester i accepted this cycle
//   tx_valid     out  1     output byte valid (registered)
//   tx_data      out  8     output byte (registered)
//   tx_ready     in   1     sink accepts byte when tx_valid & tx_ready
//   tx_grant_id  out  W     requester that sourced tx_data
// ---------------------------------------------------------------------------
module yarvi_tx_arbiter
  import yarvi_tx_arbiter_pkg::*;
#(
  parameter int  N            = 2,
  parameter int  MAX_BURST    = 64,
  parameter int  IDLE_TIMEOUT = 16,
  localparam int W            = id_width(N)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic           tx_valid,
  output logic [7:0]     tx_data,
  input  logic           tx_ready,
  output logic [W-1:0]   tx_grant_id
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  arb_state_e    state, state_next;
  logic [W-1:0]  grant, grant_next;
  logic [W-1:0]  last, last_next;
  logic [CW-1:0] count, count_next;
  logic [TW-1:0] tmo, tmo_next;
  logic          tx_valid_next;
  logic [7:0]    tx_data_next;
  logic [W-1:0]  tx_grant_id_next;

  logic          pick_any;
  logic [W-1:0]  pick_grant;
  logic [7:0]    byte_g;
  logic          valid_g;
  logic          out_free;

  yarvi_rr_pick #(.N(N)) u_pick (
    .req   (req_valid),
    .last  (last),
    .any   (pick_any),
    .grant (pick_grant)
  );

  // Byte offered by the current grant holder.
  always_comb begin
    byte_g = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == W'(i)) byte_g = req_data[8*i +: 8];
    end
  end

  assign valid_g  = req_valid[grant];
  // The output register can take a new byte when it is empty or draining
  // this cycle; this is the only tx_ready -> req_ready path.
  assign out_free = ~tx_valid | tx_ready;

  // Next-state logic. The output register keeps draining in IDLE, and a
  // burst end always passes through IDLE so the picker sees the updated
  // rotation point before choosing again.
  always_comb begin
    state_next       = state;
    grant_next       = grant;
    last_next        = last;
    count_next       = count;
    tmo_next         = tmo;
    tx_valid_next    = tx_valid & ~tx_ready;
    tx_data_next     = tx_data;
    tx_grant_id_next = tx_grant_id;
    req_ready        = '0;

    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          state_next = ARB_BURST;
          grant_next = pick_grant;
          count_next = '0;
          tmo_next   = '0;
        end
      end

      ARB_BURST: begin
        if (valid_g && out_free) begin
          req_ready[grant] = 1'b1;
          tx_valid_next    = 1'b1;
          tx_data_next     = byte_g;
          tx_grant_id_next = grant;
          count_next       = count + 1'b1;
          tmo_next         = '0;
          if (byte_g == ASCII_LF || count == CW'(MAX_BURST - 1)) begin
            state_next = ARB_IDLE;
            last_next  = grant;
          end
        end else if (!valid_g) begin
          // Only silence from the grant holder counts toward release;
          // a stalled sink does not.
          if (tmo == TW'(IDLE_TIMEOUT - 1)) begin
            state_next = ARB_IDLE;
            last_next  = grant;
          end else begin
            tmo_next = tmo + 1'b1;
          end
        end
      end

      default: state_next = ARB_IDLE;
    endcase
  end

  // State and output registers. Reset parks the rotation at N-1 so that
  // requester 0 wins first, and drops any byte still in the output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ARB_IDLE;
      grant       <= '0;
      last        <= W'(N - 1);
      count       <= '0;
      tmo         <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      tx_grant_id <= '0;
    end else begin
      state       <= state_next;
      grant       <= grant_next;
      last        <= last_next;
      count       <= count_next;
      tmo         <= tmo_next;
      tx_valid    <= tx_valid_next;
      tx_data     <= tx_data_next;
      tx_grant_id <= tx_grant_id_next;
    end
  end

endmodule

// File: tb/tb_yarvi_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_yarvi_tx_arbiter
//   Self-checking bench for yarvi_tx_arbiter with N=2, MAX_BURST=4,
//   IDLE_TIMEOUT=16: a table of per-cycle vectors, then hand-written
//   sequences for burst length, idle release and a random scoreboard run.
// ---------------------------------------------------------------------------
module tb_yarvi_tx_arbiter;

  localparam int N            = 2;
  localparam int MAX_BURST    = 4;
  localparam int IDLE_TIMEOUT = 16;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_valid;
  logic [7:0]     tx_data;
  logic           tx_ready;
  logic [0:0]     tx_grant_id;

  int total = 0;
  int bad   = 0;

  yarvi_tx_arbiter #(
    .N            (N),
    .MAX_BURST    (MAX_BURST),
    .IDLE_TIMEOUT (IDLE_TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .tx_grant_id (tx_grant_id)
  );

  always #5 clock = ~clock;

  // One cycle of stimulus and the outputs expected at mid-cycle.
  typedef struct {
    logic       rst;
    logic [1:0] rv;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       tr;
    logic [1:0] ready;
    logic       tv;
    logic [7:0] td;
    logic       gid;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clock);
    #1;
    reset     = v.rst;
    req_valid = v.rv;
    req_data  = {v.d1, v.d0};
    tx_ready  = v.tr;
  endtask

  task automatic checkOutput(input vec_t v, input int i);
    @(negedge clock);
    check($sformatf("vec%0d.req_ready", i), 32'(req_ready), 32'(v.ready));
    check($sformatf("vec%0d.tx_valid", i), 32'(tx_valid), 32'(v.tv));
    check($sformatf("vec%0d.tx_data", i), 32'(tx_data), 32'(v.td));
    check($sformatf("vec%0d.tx_grant_id", i), 32'(tx_grant_id), 32'(v.gid));
  endtask

  task automatic applyReset();
    @(posedge clock);
    #1;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tx_ready  = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [7:0] newByte();
    if ($urandom_range(5) == 0) return 8'h0A;
    return 8'($urandom_range(8'h7E, 8'h20));
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         idle_cycles;
    bit         seen;
    bit         saw_bad;
    int         n_hs;
    int         seen0, seen1;
    logic [7:0] c0, c1;
    logic [1:0] rdy;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] expb;

    // "AB\n" from req0, then req1 with a sink stall, a reset in the middle
    // of a req1 burst, and re-arbitration back to req0.
    vecs[0]  = '{1'b0, 2'b11, 8'h41, 8'h78, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 2'b11, 8'h41, 8'h78, 1'b1, 2'b01, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 2'b11, 8'h42, 8'h78, 1'b1, 2'b01, 1'b1, 8'h41, 1'b0};
    vecs[3]  = '{1'b0, 2'b11, 8'h0A, 8'h78, 1'b1, 2'b01, 1'b1, 8'h42, 1'b0};
    vecs[4]  = '{1'b0, 2'b11, 8'h43, 8'h78, 1'b1, 2'b00, 1'b1, 8'h0A, 1'b0};
    vecs[5]  = '{1'b0, 2'b11, 8'h43, 8'h78, 1'b1, 2'b10, 1'b0, 8'h0A, 1'b0};
    vecs[6]  = '{1'b0, 2'b11, 8'h43, 8'h79, 1'b1, 2'b10, 1'b1, 8'h78, 1'b1};
    vecs[7]  = '{1'b0, 2'b11, 8'h43, 8'h7A, 1'b0, 2'b00, 1'b1, 8'h79, 1'b1};
    vecs[8]  = '{1'b0, 2'b11, 8'h43, 8'h7A, 1'b0, 2'b00, 1'b1, 8'h79, 1'b1};
    vecs[9]  = '{1'b0, 2'b11, 8'h43, 8'h7A, 1'b1, 2'b10, 1'b1, 8'h79, 1'b1};
    vecs[10] = '{1'b0, 2'b11, 8'h43, 8'h0A, 1'b1, 2'b10, 1'b1, 8'h7A, 1'b1};
    vecs[11] = '{1'b0, 2'b01, 8'h43, 8'h00, 1'b1, 2'b00, 1'b1, 8'h0A, 1'b1};
    vecs[12] = '{1'b0, 2'b01, 8'h43, 8'h00, 1'b1, 2'b01, 1'b0, 8'h0A, 1'b1};
    vecs[13] = '{1'b0, 2'b01, 8'h0A, 8'h00, 1'b1, 2'b01, 1'b1, 8'h43, 1'b0};
    vecs[14] = '{1'b0, 2'b10, 8'h00, 8'h6D, 1'b1, 2'b00, 1'b1, 8'h0A, 1'b0};
    vecs[15] = '{1'b0, 2'b10, 8'h00, 8'h6D, 1'b1, 2'b10, 1'b0, 8'h0A, 1'b0};
    vecs[16] = '{1'b1, 2'b11, 8'h45, 8'h6E, 1'b1, 2'b10, 1'b1, 8'h6D, 1'b1};
    vecs[17] = '{1'b0, 2'b11, 8'h45, 8'h6E, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0};
    vecs[18] = '{1'b0, 2'b11, 8'h45, 8'h6E, 1'b1, 2'b01, 1'b0, 8'h00, 1'b0};
    vecs[19] = '{1'b0, 2'b00, 8'h45, 8'h6E, 1'b1, 2'b00, 1'b1, 8'h45, 1'b0};

    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tx_ready  = 1'b1;

    // Reset state, observed while reset is still held.
    @(posedge clock);
    @(negedge clock);
    check("reset.tx_valid", 32'(tx_valid), 0);
    check("reset.tx_data", 32'(tx_data), 0);
    check("reset.req_ready", 32'(req_ready), 0);
    check("reset.tx_grant_id", 32'(tx_grant_id), 0);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // req0 goes silent right after its grant while req1 waits: release
    // takes IDLE_TIMEOUT silent cycles plus the IDLE cycle.
    applyReset();
    req_valid = 2'b11;
    req_data  = {8'h70, 8'h50};
    @(posedge clock);
    #1;
    req_valid   = 2'b10;
    idle_cycles = 0;
    seen        = 1'b0;
    saw_bad     = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clock);
      if (req_ready[1]) begin
        seen = 1'b1;
      end else begin
        idle_cycles++;
        if (req_ready[0] || tx_valid) saw_bad = 1'b1;
      end
      @(posedge clock);
      #1;
    end
    check("timeout.req1_granted", 32'(seen), 1);
    check("timeout.silent_cycles", 32'(idle_cycles), 32'(IDLE_TIMEOUT + 1));
    check("timeout.req0_quiet", 32'(saw_bad), 0);

    // Both requesters stream non-LF bytes: runs of exactly MAX_BURST bytes,
    // alternating 0,1,0,1, each requester's bytes in order.
    applyReset();
    c0    = 8'h20;
    c1    = 8'h60;
    seen0 = 0;
    seen1 = 0;
    n_hs  = 0;
    req_valid = 2'b11;
    req_data  = {c1, c0};
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      rdy = req_ready;
      if (tx_valid && tx_ready && n_hs < 16) begin
        check($sformatf("maxburst.gid%0d", n_hs), 32'(tx_grant_id), 32'((n_hs / MAX_BURST) % 2));
        if (tx_grant_id == 1'b0) begin
          check($sformatf("maxburst.data%0d", n_hs), 32'(tx_data), 32'(8'h20 + seen0));
          seen0++;
        end else begin
          check($sformatf("maxburst.data%0d", n_hs), 32'(tx_data), 32'(8'h60 + seen1));
          seen1++;
        end
        n_hs++;
      end
      @(posedge clock);
      #1;
      if (rdy[0]) c0 = c0 + 8'd1;
      if (rdy[1]) c1 = c1 + 8'd1;
      req_data = {c1, c0};
    end
    check("maxburst.count", 32'(n_hs), 16);

    // Random traffic with a per-requester scoreboard; the tail drains.
    applyReset();
    c0 = newByte();
    c1 = newByte();
    req_data = {c1, c0};
    for (int c = 0; c < 2020; c++) begin
      @(negedge clock);
      rdy = req_ready;
      check("rand.ready_onehot0", 32'($countones(rdy) <= 1), 1);
      check("rand.ready_implies_valid", 32'(rdy & ~req_valid), 0);
      if (tx_valid && tx_ready) begin
        if (tx_grant_id == 1'b0) begin
          if (q0.size() == 0) begin
            check("rand.req0_unexpected", 32'(tx_data), 32'hFFFF);
          end else begin
            expb = q0.pop_front();
            check("rand.req0_data", 32'(tx_data), 32'(expb));
          end
        end else begin
          if (q1.size() == 0) begin
            check("rand.req1_unexpected", 32'(tx_data), 32'hFFFF);
          end else begin
            expb = q1.pop_front();
            check("rand.req1_data", 32'(tx_data), 32'(expb));
          end
        end
      end
      if (rdy[0]) q0.push_back(c0);
      if (rdy[1]) q1.push_back(c1);
      @(posedge clock);
      #1;
      if (rdy[0]) c0 = newByte();
      if (rdy[1]) c1 = newByte();
      req_data = {c1, c0};
      if (c < 2000) begin
        req_valid = 2'($urandom_range(3));
        tx_ready  = ($urandom_range(3) != 0);
      end else begin
        req_valid = 2'b00;
        tx_ready  = 1'b1;
      end
    end
    check("rand.req0_drained", 32'(q0.size()), 0);
    check("rand.req1_drained", 32'(q1.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
